// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: configurable width/polynomial/reflection, multi-byte beats,
// start/last framing with a one-cycle FINAL bubble that publishes crc_o/match_o.

module crc_lane_step #(
  parameter int               CRC_W      = 8,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(8'h07),
  parameter bit               REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [7:0]       data,
  input  logic             en,
  output logic [CRC_W-1:0] nxt
);
  logic [7:0]       b;
  logic [CRC_W-1:0] c;

  always_comb begin
    b = data;
    if (REFLECT_IN)
      for (int k = 0; k < 8; k++) b[k] = data[7-k];
    // Byte lands in the top 8 bits, then eight shift/reduce steps.
    c = crc ^ (CRC_W'(b) << (CRC_W-8));
    for (int k = 0; k < 8; k++)
      c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    nxt = en ? c : crc;
  end
endmodule

module crc_stream_engine #(
  parameter int               CRC_W       = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0] INIT        = '0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter int               DATA_BYTES  = 1,
  parameter logic [CRC_W-1:0] RESIDUE     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [8*DATA_BYTES-1:0] s_data_i,
  input  logic [DATA_BYTES-1:0]   s_keep_i,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  output logic                    s_ready_o,
  output logic [CRC_W-1:0]        crc_o,
  output logic                    crc_valid_o,
  output logic                    match_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL} state_t;

  typedef struct packed {
    logic [DATA_BYTES-1:0][7:0] data;
    logic [DATA_BYTES-1:0]      keep;
    logic                       last;
  } beat_t;

  state_t                         state_q;
  logic                           ready_q;
  logic [CRC_W-1:0]               crc_q, seed, crc_next, result;
  logic                           accept;
  beat_t                          beat;
  logic [DATA_BYTES-1:0]          lane_en;
  logic [DATA_BYTES:0][CRC_W-1:0] chain;

  function automatic logic [CRC_W-1:0] rev(input logic [CRC_W-1:0] v);
    for (int k = 0; k < CRC_W; k++) rev[k] = v[CRC_W-1-k];
  endfunction

  assign beat      = {s_data_i, s_keep_i, s_last_i};
  assign s_ready_o = ready_q & ~rst_i;
  assign accept    = s_valid_i & ready_q;
  assign seed      = (state_q == ST_IDLE) ? INIT : crc_q;
  assign chain[0]  = seed;
  assign crc_next  = chain[DATA_BYTES];
  assign result    = (REFLECT_OUT ? rev(crc_q) : crc_q) ^ XOR_OUT;

  // Lanes chain combinationally; keep only gates lanes on the closing beat.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    assign lane_en[g] = ~beat.last | beat.keep[g];
    crc_lane_step #(
      .CRC_W      (CRC_W),
      .POLY       (POLY),
      .REFLECT_IN (REFLECT_IN)
    ) u_step (
      .crc  (chain[g]),
      .data (beat.data[g]),
      .en   (lane_en[g]),
      .nxt  (chain[g+1])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      crc_q       <= INIT;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      match_o     <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      if (clear_i) begin
        state_q <= ST_IDLE;
        ready_q <= 1'b1;
        crc_q   <= INIT;
      end else begin
        case (state_q)
          ST_IDLE, ST_RUN: if (accept) begin
            crc_q   <= crc_next;
            state_q <= beat.last ? ST_FINAL : ST_RUN;
            ready_q <= ~beat.last;
          end
          ST_FINAL: begin
            crc_o       <= result;
            match_o     <= (result == RESIDUE);
            crc_valid_o <= 1'b1;
            crc_q       <= INIT;
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed + randomized bench for crc_stream_engine over CRC-8, CRC-16 and CRC-32 configs,
// checked against a bit-serial reference model.

module tb_crc_stream_engine;
  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, valid = 1'b0, last = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  keep = '0;
  int          sel = 0;

  logic        rdy_a, vld_a, match_a, rdy_b, vld_b, match_b, rdy_c, vld_c, match_c;
  logic [7:0]  crc_a;
  logic [15:0] crc_b;
  logic [31:0] crc_c;
  logic [31:0] crc_s;
  logic        vld_s, match_s, rdy_s;

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .DATA_BYTES(1), .RESIDUE(8'h00)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .s_data_i(data[7:0]), .s_keep_i(keep[0:0]),
    .s_valid_i(valid && sel == 0), .s_last_i(last), .s_ready_o(rdy_a),
    .crc_o(crc_a), .crc_valid_o(vld_a), .match_o(match_a));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .DATA_BYTES(4), .RESIDUE(16'h0000)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .s_data_i(data), .s_keep_i(keep),
    .s_valid_i(valid && sel == 1), .s_last_i(last), .s_ready_o(rdy_b),
    .crc_o(crc_b), .crc_valid_o(vld_b), .match_o(match_b));

  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .DATA_BYTES(4), .RESIDUE(32'h2144DF1C)) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .s_data_i(data), .s_keep_i(keep),
    .s_valid_i(valid && sel == 2), .s_last_i(last), .s_ready_o(rdy_c),
    .crc_o(crc_c), .crc_valid_o(vld_c), .match_o(match_c));

  always_comb begin
    crc_s = {24'h0, crc_a}; vld_s = vld_a; match_s = match_a; rdy_s = rdy_a;
    if (sel == 1) begin
      crc_s = {16'h0, crc_b}; vld_s = vld_b; match_s = match_b; rdy_s = rdy_b;
    end else if (sel == 2) begin
      crc_s = crc_c; vld_s = vld_c; match_s = match_c; rdy_s = rdy_c;
    end
  end

  int          cfg_w   [3] = '{8, 16, 32};
  int          cfg_db  [3] = '{1, 4, 4};
  bit          cfg_ref [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] cfg_poly[3] = '{32'h07, 32'h1021, 32'h04C11DB7};
  logic [31:0] cfg_init[3] = '{32'h0, 32'hFFFF, 32'hFFFFFFFF};
  logic [31:0] cfg_xor [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
  logic [31:0] cfg_res [3] = '{32'h0, 32'h0, 32'h2144DF1C};

  // Captured results from whichever engine is selected.
  logic [31:0] res_q[$];
  logic        mat_q[$];
  always @(negedge clk) if (vld_s) begin res_q.push_back(crc_s); mat_q.push_back(match_s); end

  int ncmp = 0, nfail = 0, stall0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC straight from the polynomial definition.
  function automatic logic [31:0] ref_crc(input int s, input logic [7:0] b[$]);
    int          w = cfg_w[s];
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [31:0] c = cfg_init[s], r = '0;
    logic        fb;
    foreach (b[i])
      for (int k = 0; k < 8; k++) begin
        fb = (cfg_ref[s] ? b[i][k] : b[i][7-k]) ^ c[w-1];
        c  = ((c << 1) & m[31:0]) ^ (fb ? cfg_poly[s] : 32'h0);
      end
    if (cfg_ref[s]) for (int k = 0; k < w; k++) r[k] = c[w-1-k];
    else r = c;
    return (r ^ cfg_xor[s]) & m[31:0];
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            output int stalls);
    data = d; keep = k; last = l; valid = 1'b1; stalls = 0;
    @(negedge clk);
    while (!rdy_s && stalls < 16) begin stalls++; @(negedge clk); end
    if (!rdy_s) chk("ready_timeout", 32'(stalls), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int s, input logic [7:0] b[$], input bit hold,
                            input bit extra_empty, input int max_gap);
    int n = b.size(), db = cfg_db[s], st;
    bit xe, lst;
    logic [31:0] d;
    logic [3:0]  k;
    sel = s;
    xe = extra_empty && (n % db == 0);
    if (n == 0) drive_beat($urandom, 4'h0, 1'b1, stall0);
    for (int i = 0; i < n; i += db) begin
      d = '0; k = '0;
      for (int j = 0; j < db; j++)
        if (i + j < n) begin d[8*j +: 8] = b[i+j]; k[j] = 1'b1; end
      lst = (i + db >= n) && !xe;
      drive_beat(d, k, lst, st);
      if (i == 0) stall0 = st;
      if (!lst && max_gap > 0) begin
        valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      end
    end
    if (n > 0 && xe) drive_beat($urandom, 4'h0, 1'b1, st);
    if (!hold) begin valid = 1'b0; last = 1'b0; end
  endtask

  task automatic check_one(input string tag, input logic [31:0] exp_crc, input logic exp_m);
    logic [31:0] r = 'x;
    logic        m = 1'bx;
    if (res_q.size() > 0) begin r = res_q.pop_front(); m = mat_q.pop_front(); end
    chk({tag, "_crc"}, r, exp_crc);
    chk({tag, "_match"}, {31'h0, m}, {31'h0, exp_m});
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] s9[$], f1[$], f2[$], bq[$], one[$];
    int st, s, n;
    logic [31:0] e1, e2;
    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));

    // Reset values
    #12;
    chk("rst_crc", crc_s, 32'h0);
    chk("rst_valid", {31'h0, vld_s}, 32'h0);
    chk("rst_match", {31'h0, match_s}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {31'h0, rdy_s}, 32'h1);

    // CRC-8 check value with exact latency and single-cycle ready drop
    send_frame(0, s9, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("lat_n0_valid", {31'h0, vld_s}, 32'h0);
    chk("lat_n0_ready", {31'h0, rdy_s}, 32'h0);
    @(negedge clk);
    chk("lat_n1_valid", {31'h0, vld_s}, 32'h1);
    chk("lat_n1_ready", {31'h0, rdy_s}, 32'h1);
    @(negedge clk);
    chk("lat_n2_valid", {31'h0, vld_s}, 32'h0);
    settle();
    chk("crc8_count", res_q.size(), 32'd1);
    check_one("crc8_check", 32'hF4, 1'b0);

    // CRC-16 with four-byte beats, partial last beat
    send_frame(1, s9, 1'b0, 1'b0, 0); settle();
    chk("crc16_count", res_q.size(), 32'd1);
    check_one("crc16_check", 32'h29B1, 1'b0);

    // CRC-32 check value, then residue over payload+crc
    send_frame(2, s9, 1'b0, 1'b0, 0); settle();
    check_one("crc32_check", 32'hCBF43926, 1'b0);
    bq = s9; bq.push_back(8'h26); bq.push_back(8'h39); bq.push_back(8'hF4); bq.push_back(8'hCB);
    send_frame(2, bq, 1'b0, 1'b0, 0); settle();
    check_one("crc32_residue", 32'h2144DF1C, 1'b1);

    // Back-to-back with valid held: one-cycle stall, both results right
    for (int i = 0; i < 3; i++) f1.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) f2.push_back(8'($urandom));
    send_frame(0, f1, 1'b1, 1'b0, 0);
    send_frame(0, f2, 1'b0, 1'b0, 0);
    chk("b2b_stall", 32'(stall0), 32'd1);
    settle();
    chk("b2b_count", res_q.size(), 32'd2);
    e1 = ref_crc(0, f1); e2 = ref_crc(0, f2);
    check_one("b2b_f1", e1, e1 == 32'h0);
    check_one("b2b_f2", e2, e2 == 32'h0);
    send_frame(0, f2, 1'b0, 1'b0, 0); settle();
    check_one("b2b_f2_alone", e2, e2 == 32'h0);

    // Mid-frame clear, then a full frame
    sel = 0;
    drive_beat(32'hAA, 4'h1, 1'b0, st);
    drive_beat(32'h55, 4'h1, 1'b0, st);
    valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    send_frame(0, s9, 1'b0, 1'b0, 0); settle();
    chk("clr_mid_count", res_q.size(), 32'd1);
    check_one("clr_mid", 32'hF4, 1'b0);

    // Clear coincident with the last beat discards it
    data = 32'h5A; keep = 4'h1; last = 1'b1; valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1; valid = 1'b0; last = 1'b0; clear = 1'b0;
    settle();
    chk("clr_last_count", res_q.size(), 32'd0);
    chk("clr_last_hold", crc_s, 32'hF4);

    // Clear during FINAL suppresses the result
    drive_beat(32'h11, 4'h1, 1'b1, st);
    valid = 1'b0; last = 1'b0; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    settle();
    chk("clr_final_count", res_q.size(), 32'd0);
    chk("clr_final_hold", crc_s, 32'hF4);

    // Async reset mid-frame, then a zero-byte frame hits the residue
    drive_beat(32'h12, 4'h1, 1'b0, st);
    drive_beat(32'h34, 4'h1, 1'b0, st);
    #2 rst = 1'b1;
    #1;
    chk("arst_crc", crc_s, 32'h0);
    chk("arst_valid", {31'h0, vld_s}, 32'h0);
    chk("arst_match", {31'h0, match_s}, 32'h0);
    valid = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    one.push_back(8'h00);
    send_frame(0, one, 1'b0, 1'b0, 0); settle();
    chk("arst_count", res_q.size(), 32'd1);
    check_one("arst_zero", 32'h00, 1'b1);

    // Randomized frames across all three configurations
    for (int t = 0; t < 30; t++) begin
      bq.delete();
      s = $urandom_range(0, 2);
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      send_frame(s, bq, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      settle();
      e1 = ref_crc(s, bq);
      chk($sformatf("rnd%0d_count", t), res_q.size(), 32'd1);
      check_one($sformatf("rnd%0d_s%0d_n%0d", t, s, n), e1, e1 == cfg_res[s]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised successor to the single-byte CRC-8 core: any CRC width from 8 to 32 bits, multi-byte datapath, reflection and final-XOR options.
- Adds explicit frame handshaking with start/last delimiting, a registered result with a valid pulse, and residue-based frame checking.
- Sits between the byte-stream framer and the trigger-packet validator, processing one beat per clock.

Parameters:
- CRC_W, 8: CRC width in bits; legal range 8..32.
- POLY, 8'h07: generator polynomial, normal form, implicit top bit; CRC_W bits.
- INIT, 0: register value at frame start; CRC_W bits.
- XOR_OUT, 0: value XORed into the final result; CRC_W bits.
- REFLECT_IN, 0: 1 = each input byte is processed LSB-first.
- REFLECT_OUT, 0: 1 = the register is bit-reversed before XOR_OUT is applied.
- DATA_BYTES, 1: bytes per beat; legal range 1..4.
- RESIDUE, 0: expected final value (post-reflect, post-XOR_OUT) when computed over payload+CRC; drives match_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous abort; returns to IDLE.
- s_data_i  in  8*DATA_BYTES  beat data; byte lane 0 (bits 7:0) is processed first.
- s_keep_i  in  DATA_BYTES  valid-byte mask; honoured on the last beat only, contiguous from lane 0.
- s_valid_i  in  1  beat valid.
- s_last_i  in  1  final beat of frame.
- s_ready_o  out  1  beat accepted when s_valid_i & s_ready_o.
- crc_o  out  CRC_W  finalised CRC of the last completed frame.
- crc_valid_o  out  1  one-cycle pulse when crc_o updates.
- match_o  out  1  crc_o == RESIDUE; updated together with crc_o.

Behaviour:
- Reset (async): state IDLE, internal register = INIT, crc_o = 0, crc_valid_o = 0, match_o = 0, s_ready_o = 1 once rst_i deasserts.
- States and s_ready_o:
  - IDLE: s_ready_o = 1.
  - RUN: s_ready_o = 1.
  - FINAL: s_ready_o = 0, held for exactly 1 cycle.
- IDLE, beat accepted: register seeded with INIT, then updated with the beat's bytes. Next state is RUN, or FINAL if s_last_i.
- RUN, beat accepted: register updated. If s_last_i, next state is FINAL.
- FINAL: result = reflect_out(reg) ^ XOR_OUT. crc_o and match_o are registered and crc_valid_o = 1 for one cycle; state returns to IDLE on the same edge.
- Latency: last beat accepted at edge N → crc_valid_o high from edge N+1 to edge N+2, i.e. 2 clocks after the last beat is presented.
- Byte update: per-byte bitwise (shift-register) update applied serially across lanes 0..DATA_BYTES-1 within one cycle, all combinational.
  - A byte enters the top of the register (bits CRC_W-1:CRC_W-8), reflected first if REFLECT_IN.
  - Whole datapath is CRC_W wide.
- s_keep_i:
  - Ignored on non-last beats; all lanes are processed.
  - On the last beat, only lanes with keep set are processed.
  - keep = 0 on the last beat ends the frame with no bytes from that beat.
  - Non-contiguous keep is illegal; the resulting CRC is unspecified but the FSM must still complete the frame.
- Empty frame (last beat with keep = 0 as the first beat): result = reflect_out(INIT) ^ XOR_OUT.
- Hold: crc_o and match_o hold between results. The register does not change while s_valid_i = 0.
- Backpressure: a beat offered in FINAL is not accepted. The source holds it, and it is accepted in IDLE the next cycle as a new frame's first beat.
- clear_i priority:
  - clear_i has priority over everything except rst_i.
  - Effect: next state IDLE, register = INIT, no crc_valid_o, crc_o/match_o retain their old values.
  - clear_i coincident with a last beat: the beat is discarded and no result is produced.
  - clear_i during FINAL: the result is suppressed.
- Back-to-back frames: the minimum frame period is beats + 1 cycle (the FINAL bubble).
- Reset mid-frame: immediate abort; all outputs are at reset values.

Test Plan:
- CRC_W=8, POLY=07, INIT=00, DATA_BYTES=1: stream "123456789" (0x31..0x39), last on 0x39 → crc_o = 0xF4, crc_valid_o pulses 2 clocks after the 0x39 beat is presented, s_ready_o low exactly 1 cycle.
- CRC_W=16, POLY=1021, INIT=FFFF, XOR_OUT=0, no reflect, DATA_BYTES=4: "1234","5678","9" with keep=0001 → crc_o = 0x29B1.
- CRC_W=32, POLY=04C11DB7, INIT/XOR_OUT=FFFFFFFF, both reflect, DATA_BYTES=4, RESIDUE=2144DF1C:
  - "123456789" → crc_o = 0xCBF43926, match_o = 0.
  - Same data followed by bytes 26 39 F4 CB → match_o = 1.
- Two frames back-to-back with s_valid_i held high → the second frame's first beat stalls exactly 1 cycle. Both results are correct, and the second result equals a standalone run of frame 2.
- Mid-frame clear_i, then "123456789" (CRC-8 config) → crc_o = 0xF4 with no pulse for the aborted frame. clear_i coincident with a last beat → no crc_valid_o and crc_o unchanged.
- Assert rst_i asynchronously mid-frame → outputs are 0 immediately. After release, a single-beat frame 0x00 with keep=1 (CRC-8 config) → crc_o = 0x00, match_o = 1.
